spi_txn_arbiter: RTL and testbench

Shares one single-transaction SPI master (8-bit, two slaves selected by slave_select) among NUM_REQ client requesters. Each request names a target slave and an outbound byte. The arbiter grants requests round-robin, drives the master's start/data_in/slave_select, and waits for done. It returns the received byte to the granted client with a one-cycle ack, and enforces an inter-transaction gap and a completion timeout.

---
 rtl/spi_txn_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_txn_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI master among NUM_REQ clients with gap and timeout
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_sel,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 m_start,
  output logic [7:0]           m_data_in,
  output logic                 m_slave_select,
  input  logic                 m_done,
  input  logic [7:0]           m_data_out
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam int GAP_EFF = GAP_CYCLES < 1 ? 1 : GAP_CYCLES;
  localparam int CNT_MAX = TIMEOUT_CYCLES > GAP_EFF ? TIMEOUT_CYCLES : GAP_EFF;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [3:0] NR4 = 4'(NUM_REQ);
  logic [2:0] state_q, state_d, ptr_q, ptr_d, grant_q, grant_d;
  logic [7:0] data_in_q, data_in_d, rsp_data_q, rsp_data_d;
  logic sel_q, sel_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*NUM_REQ-1:0] rr;
  logic [2:0] off, pick;
  logic [3:0] sum;
  logic [7:0] pick_data;
  logic pick_sel;
  // Round-robin pick: rotate requests so the pointer lands at bit 0, take the lowest set bit
  always_comb begin
    rr = {req, req} >> ptr_q;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rr[k]) off = k[2:0];
    sum = {1'b0, ptr_q} + {1'b0, off};
    pick = sum >= NR4 ? 3'(sum - NR4) : sum[2:0];
    pick_data = '0;
    pick_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 3'(i)) begin
        pick_data = req_data[8*i +: 8];
        pick_sel = req_sel[i];
      end
    end
  end
  // Transaction FSM; m_done is only honoured in WAIT, and done beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    data_in_d = data_in_q;
    sel_d = sel_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        grant_d = pick;
        ptr_d = pick == 3'(NUM_REQ - 1) ? 3'd0 : pick + 3'd1;
        data_in_d = pick_data;
        sel_d = pick_sel;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (m_done) begin
        rsp_data_d = m_data_out;
        rsp_err_d = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        rsp_data_d = 8'hFF;
        rsp_err_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
      RESP: begin
        cnt_d = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(GAP_EFF - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; async reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      data_in_q <= '0;
      sel_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      data_in_q <= data_in_d;
      sel_q <= sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      cnt_q <= cnt_d;
    end
  end
  // One-hot ack to the granted client during RESP only
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) ack[i] = state_q == RESP && grant_q == 3'(i);
  end
  assign m_start = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign m_data_in = data_in_q;
  assign m_slave_select = sel_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: scoreboard-driven scenarios for the SPI transaction arbiter
module tb_spi_txn_arbiter;
  localparam int N = 4;
  localparam int G = 2;
  localparam int T = 1024;
  typedef struct {
    logic [2:0] id;
    logic [7:0] d;
    logic       e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_sel = '0;
  logic [N-1:0] ack;
  logic [7:0] rsp_data, m_data_in;
  logic rsp_err, busy, m_start, m_slave_select;
  logic [2:0] grant_id;
  logic m_done = 1'b0;
  logic [7:0] m_data_out = '0;
  int tests = 0, fails = 0;
  int cyc = 0, last_ack_cyc = 0, start_cyc = 0, gap_seen = 0;
  exp_t exp_q[$];
  exp_t e;

  spi_txn_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_sel(req_sel),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .m_start(m_start), .m_data_in(m_data_in), .m_slave_select(m_slave_select),
    .m_done(m_done), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every ack must match the oldest expected completion
  always @(negedge clk) begin
    if (rst === 1'b1 && ack !== '0) begin
      last_ack_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: ack=%b rsp_data=%h, required no ack", ack, rsp_data);
      end else begin
        e = exp_q.pop_front();
        if ({ack, rsp_data, rsp_err} !== {4'b0001 << e.id, e.d, e.e}) begin
          fails++;
          $display("FAIL ack_rsp: ack=%b data=%h err=%b, required ack=%b data=%h err=%b",
                   ack, rsp_data, rsp_err, 4'b0001 << e.id, e.d, e.e);
        end
      end
    end
  end

  task automatic apply_reset();
    req = '0;
    m_done = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Acts as the SPI master for one transaction; dly < 0 means done never comes
  task automatic serve(input int dly, input logic [7:0] rx, input logic [2:0] id,
                       input logic [7:0] tx, input logic sl, input logic drop);
    int n = 0;
    while (m_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (m_start !== 1'b1) begin
      fails++;
      $display("FAIL start_wait: m_start=%b, required 1 within 100 cycles", m_start);
      return;
    end
    start_cyc = cyc;
    gap_seen = cyc - last_ack_cyc - 1;
    if (drop) req = '0;
    tests++;
    if ({grant_id, m_data_in, m_slave_select} !== {id, tx, sl}) begin
      fails++;
      $display("FAIL issue: grant=%0d tx=%h sel=%b, required grant=%0d tx=%h sel=%b",
               grant_id, m_data_in, m_slave_select, id, tx, sl);
    end
    @(negedge clk);
    tests++;
    if (m_start !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_pulse: m_start=%b busy=%b, required 0 1", m_start, busy);
    end
    if (dly < 0) begin
      exp_q.push_back('{id, 8'hFF, 1'b1});
      return;
    end
    repeat (dly - 1) @(negedge clk);
    exp_q.push_back('{id, rx, 1'b0});
    m_data_out = rx;
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_wait: busy=%b, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack, rsp_data, rsp_err, busy, grant_id, m_start, m_data_in, m_slave_select} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: %h, required 0",
               {ack, rsp_data, rsp_err, busy, grant_id, m_start, m_data_in, m_slave_select});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_data[23:16] = 8'hA5;
    req_sel[2] = 1'b1;
    req = 4'b0100;
    serve(3, 8'h3C, 3'd2, 8'hA5, 1'b1, 1'b1);
    wait_idle();
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_sel = 4'b1010;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve(10, 8'(8'hC0 + k), 3'(k), 8'(8'h10 + k), k[0], k == 3);
      if (k > 0) begin
        tests++;
        if (gap_seen < G) begin
          fails++;
          $display("FAIL rr_gap%0d: idle cycles=%0d, required >= %0d", k, gap_seen, G);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    req_data[7:0] = 8'h77;
    req_sel[0] = 1'b0;
    req = 4'b0001;
    serve(-1, 8'h00, 3'd0, 8'h77, 1'b0, 1'b1);
    wait_idle();
    tests++;
    if (last_ack_cyc - start_cyc != T + 1) begin
      fails++;
      $display("FAIL timeout_latency: %0d cycles, required %0d", last_ack_cyc - start_cyc, T + 1);
    end
    req_data[15:8] = 8'h5C;
    req = 4'b0010;
    serve(4, 8'h81, 3'd1, 8'h5C, 1'b1, 1'b1);
    wait_idle();
  endtask

  task automatic test_stale_done();
    int n = 0;
    m_data_out = 8'h99;
    m_done = 1'b1;
    repeat (3) @(negedge clk);
    req_data[23:16] = 8'h2E;
    req_sel[2] = 1'b0;
    req = 4'b0100;
    while (m_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req = '0;
    tests++;
    if (m_start !== 1'b1 || grant_id !== 3'd2) begin
      fails++;
      $display("FAIL stale_issue: m_start=%b grant=%0d, required 1 2", m_start, grant_id);
    end
    @(negedge clk);
    m_done = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || ack !== '0) begin
      fails++;
      $display("FAIL stale_done: busy=%b ack=%b, required 1 0000", busy, ack);
    end
    exp_q.push_back('{3'd2, 8'h5A, 1'b0});
    m_data_out = 8'h5A;
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    wait_idle();
    req_data[31:24] = 8'hD1;
    req_sel[3] = 1'b1;
    req = 4'b1000;
    serve(T, 8'h6B, 3'd3, 8'hD1, 1'b1, 1'b1);
    wait_idle();
  endtask

  task automatic test_reset_mid_wait();
    req_data[7:0] = 8'h0F;
    req = 4'b0001;
    serve(-1, 8'h00, 3'd0, 8'h0F, 1'b0, 1'b1);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({ack, rsp_data, rsp_err, busy, grant_id, m_start, m_data_in, m_slave_select} !== 27'd0) begin
      fails++;
      $display("FAIL reset_mid_wait: %h, required 0",
               {ack, rsp_data, rsp_err, busy, grant_id, m_start, m_data_in, m_slave_select});
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    req_data[31:24] = 8'hE4;
    req_sel[3] = 1'b0;
    req = 4'b1000;
    serve(5, 8'h17, 3'd3, 8'hE4, 1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_withdrawal();
    req_data[7:0] = 8'h11;
    req_sel[0] = 1'b0;
    req = 4'b0001;
    fork
      serve(20, 8'h42, 3'd0, 8'h11, 1'b0, 1'b1);
      begin
        repeat (6) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
      end
    join
    wait_idle();
    repeat (10) @(negedge clk);
    tests++;
    if (grant_id !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL withdrawal: grant=%0d busy=%b, required 0 0", grant_id, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stale_done();
    test_reset_mid_wait();
    test_withdrawal();
    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_ack: %0d expected acks outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
